dist_frame_sequencer: RTL and testbench
=======================================

# dist_frame_sequencer

Controller between the UART receiver, the distance processor and the UART transmitter in the AGV link. It collects the bytes of a distance frame from the receiver strobe interface and hands the assembled 16-bit distance to the processor with a start/done handshake. It then schedules the processor's 8-bit result onto the transmitter once the transmitter is idle. It owns all inter-byte timeout, framing-error and overrun policy, so the three datapath blocks stay free of protocol state.

## Interface
Parameters:
- HEADER, 8'hA5, frame start byte.
- TIMEOUT, 20000, maximum clk cycles between consecutive frame bytes; range 2..65535.

Ports:
- clk, input, 1, single system clock; all logic on rising edge.
- rst_n, input, 1, reset; synchronous, active-low.
- rx_valid, input, 1, one-cycle strobe: rx_data holds a received byte.
- rx_data, input, 8, received byte; sampled only when rx_valid=1.
- rx_err, input, 1, one-cycle framing-error strobe from the receiver.
- proc_start, output, 1, one-cycle pulse: proc_dist is valid.
- proc_dist, output, 16, assembled distance {hi, lo}; held stable from proc_start until proc_done.
- proc_done, input, 1, one-cycle strobe: proc_result is valid.
- proc_result, input, 8, processor output byte.
- tx_start, output, 1, one-cycle pulse requesting transmission of tx_data.
- tx_data, output, 8, byte to transmit; held from capture until the next capture.
- tx_busy, input, 1, transmitter is shifting a byte.
- busy, output, 1, high in every state except IDLE.
- frame_drop, output, 1, one-cycle pulse when a frame is aborted or a byte is discarded.

## Operation
- States: IDLE, GET_HI, GET_LO, PROC, TX_REQ, TX_ACK.
- IDLE:
  - rx_valid with rx_data==HEADER goes to GET_HI.
  - Any other byte is ignored silently, with no frame_drop.
- GET_HI:
  - rx_valid latches the high byte and goes to GET_LO.
- GET_LO:
  - rx_valid latches the low byte, drives proc_dist and pulses proc_start, then goes to PROC.
- PROC:
  - Waits for proc_done.
  - On proc_done, tx_data<=proc_result and the state goes to TX_REQ.
- TX_REQ:
  - If tx_busy==0, pulses tx_start and goes to TX_ACK.
  - Otherwise stays in TX_REQ.
- TX_ACK:
  - Waits for tx_busy==1, then goes to IDLE.
- Timeout:
  - A 16-bit counter clears on entry to GET_HI or GET_LO and on each accepted byte.
  - It increments every cycle in GET_HI and GET_LO.
  - When it reaches TIMEOUT-1 with no rx_valid that cycle, the state goes to IDLE and frame_drop pulses.
- rx_err:
  - In GET_HI or GET_LO: go to IDLE and pulse frame_drop. rx_err beats rx_valid in the same cycle.
  - In IDLE: ignored.
- rx_valid in PROC, TX_REQ or TX_ACK:
  - The byte is discarded, frame_drop pulses, and the state is unchanged.
- proc_done outside PROC: ignored.
- Simultaneous rx_valid and timeout expiry: the byte is accepted and the counter clears.

## Timing
- Reset (rst_n=0 at an edge):
  - State goes to IDLE and the counter clears.
  - proc_start, tx_start, busy and frame_drop are 0.
  - proc_dist=16'h0000 and tx_data=8'h00.
  - Applies from the edge after sampling, including mid-frame and mid-handshake.
  - In-flight bytes are lost, with no frame_drop.
- All outputs are registered.
- Low byte accepted at edge n: proc_start is high in cycle n+1 only.
- proc_done sampled at edge m: tx_data updates at m+1.
  - tx_start is high at m+2 at the earliest, when tx_busy was 0 at edge m+1.
- frame_drop is high for exactly the cycle after the causing edge.
- busy rises the cycle after the header is accepted and falls the cycle after TX_ACK exits.

## Configuration
- DIST_SEQ_CHECKSUM_EN defined:
  - Adds state GET_CSUM between GET_LO and PROC.
  - The expected checksum is HEADER^hi^lo.
  - A match pulses proc_start in the cycle after the checksum byte.
  - A mismatch goes to IDLE and pulses frame_drop.
  - The timeout and rx_err rules apply in GET_CSUM.
- Undefined:
  - The frame is 3 bytes and proc_start follows the low byte.

## Structure
- Package dist_seq_pkg holds:
  - the state enum;
  - the default HEADER constant;
  - DIST_W=16 and BYTE_W=8.
- Sub-module dist_seq_timer holds the inter-byte timeout counter.
  - Inputs: clear, enable.
  - Output: expired.
  - Parameterised by TIMEOUT.

## Test plan
- Reset mid-frame: rst_n low during GET_LO -> next cycle state IDLE, all outputs 0, busy=0.
- Nominal frame: bytes A5, 01, F4 with proc_done/proc_result=8'h3C after 5 cycles, tx_busy=0 -> proc_dist=16'h01F4 with one proc_start pulse; tx_data=3C; tx_start 2 cycles after proc_done; IDLE after tx_busy rises.
- Timeout: A5, 12, then no byte for TIMEOUT cycles -> frame_drop pulse, IDLE, no proc_start; a following A5,00,0A frame gives proc_dist=16'h000A.
- Error priority: rx_valid and rx_err asserted together in GET_HI -> IDLE, frame_drop=1, no byte latched.
- Transmitter backpressure: tx_busy held high 50 cycles after proc_done -> no tx_start until tx_busy falls, then one pulse; a byte arriving meanwhile -> frame_drop, state unchanged.
- Checksum (DIST_SEQ_CHECKSUM_EN): A5,01,F4,50 -> proc_start; A5,01,F4,51 -> frame_drop, no proc_start.

Source files
------------

// File: rtl/dist_seq_pkg.sv
// Shared types and constants for the distance frame sequencer.
// Optional build macro: DIST_SEQ_CHECKSUM_EN adds a trailing checksum byte.
package dist_seq_pkg;

  localparam int DIST_W = 16;
  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] HEADER_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET_HI   = 3'd1,
    S_GET_LO   = 3'd2,
    S_PROC     = 3'd3,
    S_TX_REQ   = 3'd4,
    S_TX_ACK   = 3'd5
`ifdef DIST_SEQ_CHECKSUM_EN
    ,
    S_GET_CSUM = 3'd6
`endif
  } seq_state_t;

endpackage

// File: rtl/dist_seq_timer.sv
// Inter-byte timeout counter. expired is high while the count sits at
// TIMEOUT-1, so a frame state waits TIMEOUT cycles for its next byte.
module dist_seq_timer #(
  parameter int TIMEOUT = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] cnt;

  // Count up while enabled; clear wins over enable.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= 16'd0;
    end else if (enable) begin
      cnt <= cnt + 16'd1;
    end
  end

  assign expired = (cnt == 16'(TIMEOUT - 1));

endmodule

// File: rtl/dist_frame_sequencer.sv
// Frame sequencer between UART RX, distance processor and UART TX.
// Optional build macro: DIST_SEQ_CHECKSUM_EN (frame carries HEADER^hi^lo).
//
//  state      | meaning
//  -----------+---------------------------------------------------
//  IDLE       | hunting for HEADER; other bytes dropped silently
//  GET_HI     | waiting for distance high byte
//  GET_LO     | waiting for distance low byte
//  GET_CSUM   | waiting for checksum byte (checksum build only)
//  PROC       | proc_dist presented, waiting for proc_done
//  TX_REQ     | result captured, waiting for transmitter idle
//  TX_ACK     | tx_start issued, waiting for tx_busy to confirm
module dist_frame_sequencer
  import dist_seq_pkg::*;
#(
  parameter logic [7:0] HEADER  = HEADER_DEFAULT,
  parameter int         TIMEOUT = 20000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx_valid,
  input  logic [BYTE_W-1:0]   rx_data,
  input  logic                rx_err,
  output logic                proc_start,
  output logic [DIST_W-1:0]   proc_dist,
  input  logic                proc_done,
  input  logic [BYTE_W-1:0]   proc_result,
  output logic                tx_start,
  output logic [BYTE_W-1:0]   tx_data,
  input  logic                tx_busy,
  output logic                busy,
  output logic                frame_drop
);

  seq_state_t          state, state_next;
  logic [BYTE_W-1:0]   hi_q;
  logic [DIST_W-1:0]   dist_cand;
  logic                start_nxt, txs_nxt, drop_nxt;
  logic                load_hi, load_dist, load_tx, accept;
  logic                in_get, expired, abort;

`ifdef DIST_SEQ_CHECKSUM_EN
  logic [BYTE_W-1:0]   lo_q;
  logic                load_lo;
  assign in_get    = (state == S_GET_HI) || (state == S_GET_LO) || (state == S_GET_CSUM);
  assign dist_cand = {hi_q, lo_q};
`else
  assign in_get    = (state == S_GET_HI) || (state == S_GET_LO);
  assign dist_cand = {hi_q, rx_data};
`endif

  // rx_err beats rx_valid; a byte landing on the expiry cycle is still taken.
  assign abort = rx_err || (!rx_valid && expired);

  dist_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (accept || !in_get),
    .enable  (in_get),
    .expired (expired)
  );

  // Next-state and registered-output intents.
  always_comb begin
    state_next = state;
    start_nxt  = 1'b0;
    txs_nxt    = 1'b0;
    drop_nxt   = 1'b0;
    load_hi    = 1'b0;
    load_dist  = 1'b0;
    load_tx    = 1'b0;
    accept     = 1'b0;
`ifdef DIST_SEQ_CHECKSUM_EN
    load_lo    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (rx_valid && (rx_data == HEADER)) state_next = S_GET_HI;
      end
      S_GET_HI: begin
        if (abort) begin
          state_next = S_IDLE;
          drop_nxt   = 1'b1;
        end else if (rx_valid) begin
          accept     = 1'b1;
          load_hi    = 1'b1;
          state_next = S_GET_LO;
        end
      end
      S_GET_LO: begin
        if (abort) begin
          state_next = S_IDLE;
          drop_nxt   = 1'b1;
        end else if (rx_valid) begin
          accept     = 1'b1;
`ifdef DIST_SEQ_CHECKSUM_EN
          load_lo    = 1'b1;
          state_next = S_GET_CSUM;
`else
          load_dist  = 1'b1;
          start_nxt  = 1'b1;
          state_next = S_PROC;
`endif
        end
      end
`ifdef DIST_SEQ_CHECKSUM_EN
      S_GET_CSUM: begin
        if (abort) begin
          state_next = S_IDLE;
          drop_nxt   = 1'b1;
        end else if (rx_valid) begin
          accept = 1'b1;
          if (rx_data == (HEADER ^ hi_q ^ lo_q)) begin
            load_dist  = 1'b1;
            start_nxt  = 1'b1;
            state_next = S_PROC;
          end else begin
            state_next = S_IDLE;
            drop_nxt   = 1'b1;
          end
        end
      end
`endif
      S_PROC: begin
        drop_nxt = rx_valid;
        if (proc_done) begin
          load_tx    = 1'b1;
          state_next = S_TX_REQ;
        end
      end
      S_TX_REQ: begin
        drop_nxt = rx_valid;
        if (!tx_busy) begin
          txs_nxt    = 1'b1;
          state_next = S_TX_ACK;
        end
      end
      S_TX_ACK: begin
        drop_nxt = rx_valid;
        if (tx_busy) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      hi_q       <= '0;
      proc_dist  <= '0;
      tx_data    <= '0;
      proc_start <= 1'b0;
      tx_start   <= 1'b0;
      frame_drop <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      proc_start <= start_nxt;
      tx_start   <= txs_nxt;
      frame_drop <= drop_nxt;
      busy       <= (state_next != S_IDLE);
      if (load_hi)   hi_q      <= rx_data;
      if (load_dist) proc_dist <= dist_cand;
      if (load_tx)   tx_data   <= proc_result;
    end
  end

`ifdef DIST_SEQ_CHECKSUM_EN
  // Low byte is held until the checksum confirms the frame.
  always_ff @(posedge clk) begin
    if (!rst_n)       lo_q <= '0;
    else if (load_lo) lo_q <= rx_data;
  end
`endif

endmodule

// File: tb/tb_dist_frame_sequencer.sv
// Scoreboard bench for dist_frame_sequencer: stimulus pushes expected
// proc_start/tx_start/frame_drop events, a negedge monitor pops and compares.
module tb_dist_frame_sequencer;

  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid, rx_err, proc_done, tx_busy;
  logic [7:0]  rx_data, proc_result;
  logic        proc_start, tx_start, busy, frame_drop;
  logic [15:0] proc_dist;
  logic [7:0]  tx_data;

  int tests = 0;
  int fails = 0;

  logic [15:0] exp_dist_q[$];
  logic [7:0]  exp_tx_q[$];
  int          exp_drop_q[$];

  dist_frame_sequencer #(.HEADER(8'hA5), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_err      (rx_err),
    .proc_start  (proc_start),
    .proc_dist   (proc_dist),
    .proc_done   (proc_done),
    .proc_result (proc_result),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .busy        (busy),
    .frame_drop  (frame_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every output event must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (proc_start) begin
        if (exp_dist_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_proc_start: dist %0h, none expected", proc_dist);
        end else check("proc_dist", {16'h0, proc_dist}, {16'h0, exp_dist_q.pop_front()});
      end
      if (tx_start) begin
        if (exp_tx_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_tx_start: data %0h, none expected", tx_data);
        end else check("tx_data", {24'h0, tx_data}, {24'h0, exp_tx_q.pop_front()});
      end
      if (frame_drop) begin
        if (exp_drop_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_frame_drop: pulse seen, none expected");
        end else check("frame_drop_event", 32'd1, 32'(exp_drop_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo);
    exp_dist_q.push_back({hi, lo});
    send_byte(8'hA5);
    send_byte(hi);
    send_byte(lo);
`ifdef DIST_SEQ_CHECKSUM_EN
    send_byte(8'hA5 ^ hi ^ lo);
`endif
  endtask

  // Complete processing and transmit with an idle transmitter.
  task automatic finish_frame(input logic [7:0] res);
    repeat (5) tick();
    proc_result = res; proc_done = 1'b1;
    exp_tx_q.push_back(res);
    tick();
    proc_done = 1'b0;
    tick();
    tx_busy = 1'b1;
    tick();
    tx_busy = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
    proc_done = 1'b0; proc_result = 8'h00; tx_busy = 1'b0;
    repeat (3) tick();
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_proc_start", {31'h0, proc_start}, 32'd0);
    check("rst_tx_start", {31'h0, tx_start}, 32'd0);
    check("rst_frame_drop", {31'h0, frame_drop}, 32'd0);
    check("rst_proc_dist", {16'h0, proc_dist}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Noise in IDLE and stray proc_done are ignored.
    send_byte(8'h33);
    rx_err = 1'b1; tick(); rx_err = 1'b0;
    proc_result = 8'hEE; proc_done = 1'b1; tick(); proc_done = 1'b0;
    check("idle_busy", {31'h0, busy}, 32'd0);
    check("idle_tx_data", {24'h0, tx_data}, 32'h0);

    // Nominal frame with explicit handshake timing.
    send_frame(8'h01, 8'hF4);
    check("nom_start_now", {31'h0, proc_start}, 32'd1);
    check("nom_busy", {31'h0, busy}, 32'd1);
    tick();
    check("nom_start_once", {31'h0, proc_start}, 32'd0);
    repeat (4) tick();
    proc_result = 8'h3C; proc_done = 1'b1;
    exp_tx_q.push_back(8'h3C);
    tick();
    proc_done = 1'b0;
    check("nom_tx_data", {24'h0, tx_data}, 32'h3C);
    check("nom_tx_start_early", {31'h0, tx_start}, 32'd0);
    tick();
    check("nom_tx_start", {31'h0, tx_start}, 32'd1);
    tx_busy = 1'b1;
    tick();
    check("nom_idle", {31'h0, busy}, 32'd0);
    tx_busy = 1'b0;
    tick();

    // Timeout: header and high byte, then silence.
    exp_drop_q.push_back(1);
    send_byte(8'hA5);
    send_byte(8'h12);
`ifdef DIST_SEQ_CHECKSUM_EN
    send_byte(8'h34);
`endif
    repeat (TMO - 1) tick();
    check("tmo_not_yet", {31'h0, frame_drop}, 32'd0);
    check("tmo_busy_before", {31'h0, busy}, 32'd1);
    tick();
    check("tmo_drop", {31'h0, frame_drop}, 32'd1);
    check("tmo_idle", {31'h0, busy}, 32'd0);
    tick();
    send_frame(8'h00, 8'h0A);
    finish_frame(8'h11);
    check("tmo_recover_idle", {31'h0, busy}, 32'd0);

    // Byte arriving on the expiry cycle is accepted.
    exp_dist_q.push_back(16'h0203);
    send_byte(8'hA5);
    send_byte(8'h02);
`ifdef DIST_SEQ_CHECKSUM_EN
    send_byte(8'h03);
    repeat (TMO - 1) tick();
    send_byte(8'hA5 ^ 8'h02 ^ 8'h03);
`else
    repeat (TMO - 1) tick();
    send_byte(8'h03);
`endif
    check("edge_accept_start", {31'h0, proc_start}, 32'd1);
    finish_frame(8'h22);

    // rx_err beats rx_valid in GET_HI.
    exp_drop_q.push_back(1);
    send_byte(8'hA5);
    rx_err = 1'b1; rx_data = 8'h77; rx_valid = 1'b1;
    tick();
    rx_err = 1'b0; rx_valid = 1'b0;
    check("err_drop", {31'h0, frame_drop}, 32'd1);
    check("err_idle", {31'h0, busy}, 32'd0);
    send_frame(8'h05, 8'h06);
    finish_frame(8'h33);

    // Transmitter backpressure with a stray byte during the wait.
    send_frame(8'h02, 8'h00);
    repeat (2) tick();
    tx_busy = 1'b1;
    proc_result = 8'h55; proc_done = 1'b1;
    exp_tx_q.push_back(8'h55);
    tick();
    proc_done = 1'b0;
    repeat (20) tick();
    exp_drop_q.push_back(1);
    send_byte(8'hA5);
    check("bp_stray_drop", {31'h0, frame_drop}, 32'd1);
    repeat (29) tick();
    check("bp_still_busy", {31'h0, busy}, 32'd1);
    tx_busy = 1'b0;
    tick();
    check("bp_tx_start", {31'h0, tx_start}, 32'd1);
    tx_busy = 1'b1;
    tick();
    check("bp_idle", {31'h0, busy}, 32'd0);
    tx_busy = 1'b0;
    tick();

`ifdef DIST_SEQ_CHECKSUM_EN
    // Checksum match and mismatch.
    exp_dist_q.push_back(16'h01F4);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'hF4); send_byte(8'h50);
    check("csum_ok_start", {31'h0, proc_start}, 32'd1);
    finish_frame(8'h44);
    exp_drop_q.push_back(1);
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'hF4); send_byte(8'h51);
    check("csum_bad_drop", {31'h0, frame_drop}, 32'd1);
    check("csum_bad_idle", {31'h0, busy}, 32'd0);
    tick();
`endif

    // Reset mid-frame (GET_LO) with a non-zero tx_data and proc_dist.
    send_byte(8'hA5);
    send_byte(8'h01);
    rst_n = 1'b0;
    tick();
    check("midrst_busy", {31'h0, busy}, 32'd0);
    check("midrst_proc_dist", {16'h0, proc_dist}, 32'h0);
    check("midrst_tx_data", {24'h0, tx_data}, 32'h0);
    check("midrst_drop", {31'h0, frame_drop}, 32'd0);
    rst_n = 1'b1;
    tick();
    send_frame(8'h00, 8'h0A);
    finish_frame(8'h66);
    repeat (3) tick();

    check("dist_queue_empty", 32'(exp_dist_q.size()), 32'd0);
    check("tx_queue_empty", 32'(exp_tx_q.size()), 32'd0);
    check("drop_queue_empty", 32'(exp_drop_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
